// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
// Bundles the three buses around the ALU issue controller:
//   req_* : requester -> sequencer operation handshake
//   alu_* : sequencer -> ALU datapath operands/select, ALU -> sequencer result
//   rsp_* : sequencer -> requester result handshake
// Modports:
//   slave  : view of the sequencer itself (accepts requests, owns alu_* drive)
//   master : view of the surrounding environment (requester + ALU datapath)
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if;
    logic               req_valid;
    logic               req_ready;
    logic [3:0]         req_opcode;
    logic               req_s;
    logic [31:0]        req_op1;
    logic [31:0]        req_op2;
    logic [15:0]        req_imm;
    logic [4:0]         req_shamt;

    logic [3:0]         alu_sel;
    logic [31:0]        alu_in1;
    logic [31:0]        alu_in2;
    logic [15:0]        alu_imm;
    logic [4:0]         alu_shamt;
    logic               alu_s_bit;
    logic [31:0]        alu_result;
    logic [3:0]         alu_flags;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_result;
    logic [3:0]         rsp_flags;
    logic               rsp_err;

    modport slave (
        input  req_valid, req_opcode, req_s, req_op1, req_op2, req_imm, req_shamt,
        output req_ready,
        output alu_sel, alu_in1, alu_in2, alu_imm, alu_shamt, alu_s_bit,
        input  alu_result, alu_flags,
        output rsp_valid, rsp_result, rsp_flags, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_opcode, req_s, req_op1, req_op2, req_imm, req_shamt,
        input  req_ready,
        input  alu_sel, alu_in1, alu_in2, alu_imm, alu_shamt, alu_s_bit,
        output alu_result, alu_flags,
        input  rsp_valid, rsp_result, rsp_flags, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Multi-cycle issue controller in front of the ALU datapath. Accepts one
// operation per request handshake, presents it to the ALU for an
// opcode-dependent number of cycles, captures the result and returns it on
// the response handshake. Owns the architectural NZCV flags register.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   flush  : synchronous abort of any in-flight operation
//   bus    : req_*/alu_*/rsp_* buses (slave modport)
//   busy   : high whenever the sequencer is not IDLE
// Parameters:
//   BASE_LAT : issue-to-capture cycles for single-cycle ops (1..15)
//   MUL_LAT  : issue-to-capture cycles for MUL (1..15)
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int BASE_LAT = 1,
    parameter int MUL_LAT  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    alu_op_sequencer_if.slave     bus,
    output logic                  busy
);

    // Latencies must fit the 4-bit down-counter and be at least one cycle.
    if (BASE_LAT < 1 || BASE_LAT > 15 || MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_lat
        $error("alu_op_sequencer: BASE_LAT and MUL_LAT must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_CMP   = 4'b1011;
    localparam logic [3:0] BASE_CNT = 4'(BASE_LAT - 1);
    localparam logic [3:0] MUL_CNT  = 4'(MUL_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic [3:0]  flags_q, flags_d;
    logic        err_q, err_d;

    logic [3:0]  opcode_q, opcode_d;
    logic        s_q, s_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [15:0] imm_q, imm_d;
    logic [4:0]  shamt_q, shamt_d;

    logic        latch_en;
    logic        reserved_op;

    assign reserved_op = (bus.req_opcode[3:2] == 2'b11);
    // A flush in IDLE also blocks the operand latch so nothing is half-accepted.
    assign latch_en    = (state_q == IDLE) && bus.req_valid && !flush;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;

        opcode_d = latch_en ? bus.req_opcode : opcode_q;
        s_d      = latch_en ? bus.req_s      : s_q;
        op1_d    = latch_en ? bus.req_op1    : op1_q;
        op2_d    = latch_en ? bus.req_op2    : op2_q;
        imm_d    = latch_en ? bus.req_imm    : imm_q;
        shamt_d  = latch_en ? bus.req_shamt  : shamt_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (reserved_op) begin
                        // Reserved opcodes never reach the ALU: respond at once.
                        state_d  = DONE;
                        err_d    = 1'b1;
                        result_d = 32'd0;
                    end else begin
                        state_d = EXEC;
                        cnt_d   = (bus.req_opcode == OP_MUL) ? MUL_CNT : BASE_CNT;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    // CMP only produces flags; its arithmetic result is dropped.
                    result_d = (opcode_q == OP_CMP) ? 32'd0 : bus.alu_result;
                    if (s_q || opcode_q == OP_CMP) begin
                        flags_d = bus.alu_flags;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides everything, including a capture in the same cycle.
        if (flush) begin
            state_d  = IDLE;
            cnt_d    = 4'd0;
            result_d = result_q;
            flags_d  = flags_q;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            result_q <= 32'd0;
            flags_q  <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

    // Operand latches are only observable through the EXEC-gated alu_* outputs,
    // so they need no reset.
    always_ff @(posedge clk) begin
        opcode_q <= opcode_d;
        s_q      <= s_d;
        op1_q    <= op1_d;
        op2_q    <= op2_d;
        imm_q    <= imm_d;
        shamt_q  <= shamt_d;
    end

    assign busy           = (state_q != IDLE);
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.rsp_valid  = (state_q == DONE);
    assign bus.rsp_result = result_q;
    assign bus.rsp_flags  = flags_q;
    assign bus.rsp_err    = err_q;

    assign bus.alu_sel    = (state_q == EXEC) ? opcode_q : 4'd0;
    assign bus.alu_in1    = (state_q == EXEC) ? op1_q    : 32'd0;
    assign bus.alu_in2    = (state_q == EXEC) ? op2_q    : 32'd0;
    assign bus.alu_imm    = (state_q == EXEC) ? imm_q    : 16'd0;
    assign bus.alu_shamt  = (state_q == EXEC) ? shamt_q  : 5'd0;
    assign bus.alu_s_bit  = (state_q == EXEC) ? s_q      : 1'b0;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle issue controller in front of the ALU datapath (adder, subtractor, multiplier, bitwise ops, shifts/rotate, MOV, compare, flags unit). It accepts one operation per request handshake and drives the ALU mux select and operand buses. It waits an opcode-dependent latency, then captures the result and returns it through a response handshake. It also owns the architectural NZCV flags register.

Parameters:
BASE_LAT, 1, cycles from issue to result capture for all single-cycle ops (1..15)
MUL_LAT, 4, cycles from issue to result capture for MUL (1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of in-flight op
req_valid  in  1  request valid
req_ready  out  1  request ready
req_opcode  in  4  operation code (map below)
req_s  in  1  set-flags bit
req_op1  in  32  operand 1
req_op2  in  32  operand 2
req_imm  in  16  immediate for MOVN
req_shamt  in  5  shift/rotate amount
alu_sel  out  4  ALU result mux select (= latched opcode)
alu_in1  out  32  ALU operand 1
alu_in2  out  32  ALU operand 2
alu_imm  out  16  ALU immediate
alu_shamt  out  5  ALU shift amount
alu_s_bit  out  1  s_bit to flags unit
alu_result  in  32  ALU mux output
alu_flags  in  4  flags unit output {N,Z,C,V}
rsp_valid  out  1  response valid
rsp_ready  in  1  response ready
rsp_result  out  32  captured result
rsp_flags  out  4  current flags register
rsp_err  out  1  reserved opcode was issued
busy  out  1  high in any state except IDLE

Behaviour:
- Opcode map: 0000 ADD, 0001 SUB, 0010 MUL, 0011 AND, 0100 OR, 0101 MOVREG, 0110 XOR, 0111 LSR, 1000 LSL, 1001 ROR, 1010 MOVN, 1011 CMP, 1100-1111 reserved.
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0 except req_ready, which is 1 once in IDLE.
  - flags register 0, result register 0, counter 0.
  - Reset mid-op discards the op; no response is produced.
- States: IDLE, EXEC, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch opcode, s, op1, op2, imm and shamt.
  - Load counter with (MUL ? MUL_LAT : BASE_LAT)-1, then go to EXEC.
  - Reserved opcode: go straight to DONE with rsp_err=1, result 0, flags unchanged, no EXEC cycle.
- EXEC:
  - alu_* outputs are driven from the latched regs and held stable for the whole op.
  - Counter decrements each cycle.
  - When counter==0:
    - Capture alu_result into the result reg. For CMP, capture 0 instead.
    - If s==1 or opcode==CMP, flags <= alu_flags; otherwise flags are unchanged.
    - Go to DONE.
- DONE:
  - rsp_valid=1; rsp_result and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On that handshake, go to IDLE and clear rsp_err.
- Latency:
  - Accept at edge k; capture at edge k+L, where L = BASE_LAT or MUL_LAT.
  - rsp_valid is high after edge k+L.
  - Throughput is at most one op per L+2 cycles.
- req_ready=0 in EXEC and DONE. New requests are never dropped; the requester holds them.
- alu_* outputs are 0 in IDLE.
- rsp_flags always reflects the flags register, including in IDLE.
- flush (sync, highest priority after reset):
  - From any state, next state is IDLE.
  - No result or flags update, rsp_valid=0.
  - flush in the capture cycle wins over the capture.
- Simultaneous rsp_ready and a new req_valid in DONE: the response completes; the request is accepted only in the following IDLE cycle.
- Widths: the result is 32-bit as returned by the ALU (overflow wraps in the ALU). The counter is 4 bits. Parameters of 0 are illegal (assertion).

Test Plan:
1. BASE_LAT=1; ADD op1=4, op2=10, s=0 -> alu_sel=0000 for 1 cycle; rsp_valid 1 cycle after accept; rsp_result=14; rsp_flags=0000 unchanged.
2. MUL_LAT=4; MUL op1=30, op2=4 -> req_ready low through 4 EXEC cycles; rsp_result=120 after edge k+4; alu_in1/in2 stable every EXEC cycle.
3. SUB op1=0, op2=1, s=1 with the flags model returning 1000 -> rsp_result=0xFFFFFFFF, flags=1000. A following ADD with s=0 -> flags stay 1000.
4. CMP op1=10, op2=10 with s=0 and the model returning 0110 -> flags=0110, rsp_result=0.
5. rsp_ready low for 3 cycles in DONE while the next req_valid is held -> rsp_valid, result and err stable; req_ready=0; the next op is accepted the cycle after return to IDLE.
6. Opcode 1111 -> rsp_err=1 the cycle after accept, no EXEC, flags unchanged. Then MUL with rst_n pulsed low during EXEC -> all outputs 0 immediately, flags 0000, no response. Flush during MUL EXEC -> IDLE next cycle, no response.
